reset_seq: RTL and testbench
============================

RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter NUM_DOM, default 4, number of sequenced reset domains (legal 1..8).
REQ-002 Parameter STAGE_DLY, default 16, clk cycles between successive domain releases (legal 1..256).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset, driven by the upstream reset-synchronizer stage.
REQ-005 Port test_mode  input  1  DFT bypass; 1 = outputs follow reset directly.
REQ-006 Port soft_req  input  1  soft-reset request, 4-phase (present only with RESET_SEQ_SOFT_RESET_EN).
REQ-007 Port soft_ack  output  1  soft-reset acknowledge, 4-phase (present only with RESET_SEQ_SOFT_RESET_EN).
REQ-008 Port dom_reset  output  NUM_DOM  per-domain active-high reset; bit 0 released first.
REQ-009 Port seq_done  output  1  1 = all domains released, sequence complete.

Function
REQ-010 FSM states: HOLD, RELEASE, RUN, SOFT_HOLD, SOFT_ACK; counter cnt of width clog2(STAGE_DLY+1); domain index idx.
REQ-011 Edge numbering: edge 1 = first rising edge with reset=0; the counter advances once per edge.
REQ-012 dom_reset[i] SHALL be 1 before edge (i+1)*STAGE_DLY and 0 from that edge on, i = 0..NUM_DOM-1.
REQ-013 HOLD->RELEASE at edge STAGE_DLY (releasing bit 0); RELEASE->RUN at edge NUM_DOM*STAGE_DLY (last bit released).
REQ-014 seq_done SHALL be 1 from edge NUM_DOM*STAGE_DLY+1 while in RUN; 0 in all other states.
REQ-015 All outputs registered, except the test_mode bypass mux.
REQ-016 STAGE_DLY=1: one domain released per edge, no skipped or double releases; NUM_DOM=1: RELEASE->RUN on same edge as bit 0.
REQ-017 Counter SHALL never wrap: cleared on each stage release, held at 0 in RUN.
REQ-018 test_mode=1: dom_reset = {NUM_DOM{reset}}, seq_done = ~reset combinationally; FSM keeps running underneath.
REQ-019 Soft reset: soft_req sampled 1 in RUN -> SOFT_HOLD; from that edge dom_reset = all 1, seq_done = 0.
REQ-020 SOFT_HOLD lasts STAGE_DLY edges, then SOFT_ACK with soft_ack = 1.
REQ-021 In SOFT_ACK, edge sampling soft_req=0: soft_ack = 0, cnt = 0, enter HOLD; release proceeds per REQ-012/013 counted from that edge.
REQ-022 soft_req sampled in HOLD or RELEASE SHALL be ignored (no latching); serviced only once in RUN.
REQ-023 soft_req dropped during SOFT_HOLD: soft_ack still pulses one cycle at entry to SOFT_ACK, then release proceeds.

Reset
REQ-024 reset=1 at any edge, any state (including mid-release or mid-soft): next state HOLD, cnt=0, idx=0, dom_reset=all 1, seq_done=0, soft_ack=0.
REQ-025 reset takes priority over soft_req and over any counter expiry on the same edge.
REQ-026 No asynchronous reset path; no other storage requires initialization.

Configuration
REQ-027 Macro RESET_SEQ_SOFT_RESET_EN defined: soft_req/soft_ack ports and SOFT_HOLD/SOFT_ACK states present per REQ-019..023.
REQ-028 Macro undefined: ports and soft states absent; RUN is terminal until reset; all other behaviour identical.

Verification
REQ-029 NUM_DOM=4, STAGE_DLY=16, reset 1->0 -> dom_reset 1111 -> 1110@16 -> 1100@32 -> 1000@48 -> 0000@64; seq_done=1@65.
REQ-030 STAGE_DLY=1, NUM_DOM=4 -> bits clear at edges 1,2,3,4; seq_done=1@5; no glitch back to 1.
REQ-031 reset pulsed 1 for one cycle at edge 40 -> dom_reset=1111 next edge; full sequence restarts, bit 0 released 16 edges after reset drops.
REQ-032 (macro on) soft_req=1 in RUN at edge E -> dom_reset=1111@E, soft_ack=1@E+16; soft_req=0@F -> soft_ack=0@F, bit 0 released @F+16.
REQ-033 test_mode=1, reset toggled mid-RELEASE -> dom_reset=1111/0000 and seq_done track reset same cycle; test_mode=0 -> registered sequence values resume.
REQ-034 (macro on) soft_req=1 during RELEASE at edge 20 -> no effect; sequence completes at edge 64; soft_req still 1 at RUN -> SOFT_HOLD entered @65.

Source files
------------

// File: rtl/reset_seq.sv
// Staged reset release sequencer: releases NUM_DOM domains STAGE_DLY clocks apart.
// Define RESET_SEQ_SOFT_RESET_EN to add the soft_req/soft_ack soft-reset handshake.
module reset_seq #(
  parameter int NUM_DOM   = 4,
  parameter int STAGE_DLY = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               test_mode,
`ifdef RESET_SEQ_SOFT_RESET_EN
  input  logic               soft_req,
  output logic               soft_ack,
`endif
  output logic [NUM_DOM-1:0] dom_reset,
  output logic               seq_done
);

  localparam int CW = $clog2(STAGE_DLY + 1);
  localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DOM - 1);

  typedef enum logic [2:0] {
    HOLD,
    RELEASE,
`ifdef RESET_SEQ_SOFT_RESET_EN
    RUN,
    SOFT_HOLD,
    SOFT_ACK
`else
    RUN
`endif
  } state_t;

  state_t              state_q;
  state_t              state_n;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_n;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       idx_n;
  logic [NUM_DOM-1:0]  dom_q;
  logic [NUM_DOM-1:0]  dom_n;
  logic                done_q;
  logic                done_n;
  logic                expire;
`ifdef RESET_SEQ_SOFT_RESET_EN
  logic                ack_q;
  logic                ack_n;
`endif

  assign expire = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '1;
      done_q  <= 1'b0;
`ifdef RESET_SEQ_SOFT_RESET_EN
      ack_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
      dom_q   <= dom_n;
      done_q  <= done_n;
`ifdef RESET_SEQ_SOFT_RESET_EN
      ack_q   <= ack_n;
`endif
    end
  end

  // cnt restarts at every release so it never exceeds STAGE_DLY-1
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    idx_n   = idx_q;
    unique case (state_q)
      HOLD, RELEASE: begin
        if (expire) begin
          cnt_n = '0;
          if (idx_q == IDX_LAST) begin
            state_n = RUN;
            idx_n   = '0;
          end else begin
            state_n = RELEASE;
            idx_n   = idx_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_n = '0;
`ifdef RESET_SEQ_SOFT_RESET_EN
        if (soft_req) state_n = SOFT_HOLD;
`endif
      end
`ifdef RESET_SEQ_SOFT_RESET_EN
      SOFT_HOLD: begin
        if (expire) begin
          cnt_n   = '0;
          state_n = SOFT_ACK;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      SOFT_ACK: begin
        cnt_n = '0;
        idx_n = '0;
        if (!soft_req) state_n = HOLD;
      end
`endif
      default: begin
        state_n = HOLD;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  always_comb begin
    dom_n  = dom_q;
    done_n = 1'b0;
`ifdef RESET_SEQ_SOFT_RESET_EN
    ack_n  = 1'b0;
`endif
    unique case (state_q)
      HOLD, RELEASE: begin
        if (expire) begin
          for (int i = 0; i < NUM_DOM; i++) begin
            if (idx_q == IW'(i)) dom_n[i] = 1'b0;
          end
        end
      end
      RUN: begin
        done_n = 1'b1;
`ifdef RESET_SEQ_SOFT_RESET_EN
        if (soft_req) begin
          dom_n  = '1;
          done_n = 1'b0;
        end
`endif
      end
`ifdef RESET_SEQ_SOFT_RESET_EN
      SOFT_HOLD: begin
        dom_n = '1;
        ack_n = expire;
      end
      SOFT_ACK: begin
        dom_n = '1;
        ack_n = soft_req;
      end
`endif
      default: begin
        dom_n = '1;
      end
    endcase
  end

  // DFT bypass is the only combinational path to the outputs
  assign dom_reset = test_mode ? {NUM_DOM{reset}} : dom_q;
  assign seq_done  = test_mode ? ~reset : done_q;
`ifdef RESET_SEQ_SOFT_RESET_EN
  assign soft_ack  = ack_q;
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: a slow (4x16) and a fast (4x1) instance against an edge-count model.
// Soft-reset steps run only when RESET_SEQ_SOFT_RESET_EN is defined.
module tb_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       tm;
  logic       sreq;
  logic [3:0] dom_a;
  logic [3:0] dom_b;
  logic       done_a;
  logic       done_b;
`ifdef RESET_SEQ_SOFT_RESET_EN
  logic       ack_a;
  logic       ack_b;
  localparam bit SOFT = 1'b1;
`else
  localparam bit SOFT = 1'b0;
`endif

  reset_seq #(.NUM_DOM(4), .STAGE_DLY(16)) u_a (
    .clk       (clk),
    .reset     (rst),
    .test_mode (tm),
`ifdef RESET_SEQ_SOFT_RESET_EN
    .soft_req  (sreq),
    .soft_ack  (ack_a),
`endif
    .dom_reset (dom_a),
    .seq_done  (done_a)
  );

  reset_seq #(.NUM_DOM(4), .STAGE_DLY(1)) u_b (
    .clk       (clk),
    .reset     (rst),
    .test_mode (tm),
`ifdef RESET_SEQ_SOFT_RESET_EN
    .soft_req  (sreq),
    .soft_ack  (ack_b),
`endif
    .dom_reset (dom_b),
    .seq_done  (done_b)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // model: e = edges since release started; ph 0=sequence, 1=soft hold, 2=soft ack
  int   e   [2];
  int   ph  [2];
  int   h   [2];
  logic ackm[2];

  function automatic int sd(input int k);
    return (k == 0) ? 16 : 1;
  endfunction

  task automatic model_edge(input int k);
    if (rst) begin
      e[k] = 0; ph[k] = 0; h[k] = 0; ackm[k] = 1'b0;
    end else if (ph[k] == 0) begin
      if (SOFT && sreq && e[k] >= 4 * sd(k)) begin
        ph[k] = 1; h[k] = 0; ackm[k] = 1'b0;
      end else begin
        e[k] = e[k] + 1;
      end
    end else if (ph[k] == 1) begin
      h[k] = h[k] + 1;
      if (h[k] == sd(k)) begin
        ph[k] = 2; ackm[k] = 1'b1;
      end
    end else if (!sreq) begin
      ph[k] = 0; e[k] = 0; ackm[k] = 1'b0;
    end
  endtask

  function automatic logic [3:0] exp_dom(input int k);
    logic [3:0] r;
    if (tm) return {4{rst}};
    if (ph[k] != 0) return 4'hF;
    for (int i = 0; i < 4; i++) r[i] = (e[k] < (i + 1) * sd(k));
    return r;
  endfunction

  function automatic logic exp_done(input int k);
    if (tm) return ~rst;
    return (ph[k] == 0) && (e[k] >= 4 * sd(k) + 1);
  endfunction

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s t=%0t obs=%h exp=%h", tag, $time, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check("a_dom",  {4'h0, dom_a},  {4'h0, exp_dom(0)});
      check("a_done", {7'h0, done_a}, {7'h0, exp_done(0)});
      check("b_dom",  {4'h0, dom_b},  {4'h0, exp_dom(1)});
      check("b_done", {7'h0, done_b}, {7'h0, exp_done(1)});
`ifdef RESET_SEQ_SOFT_RESET_EN
      check("a_ack",  {7'h0, ack_a},  {7'h0, ackm[0]});
      check("b_ack",  {7'h0, ack_b},  {7'h0, ackm[1]});
`endif
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      e[k] = 0; ph[k] = 0; h[k] = 0; ackm[k] = 1'b0;
    end
    rst = 1'b1; tm = 1'b0; sreq = 1'b0;
    tick(3);
    // full release from reset
    rst = 1'b0;
    tick(70);
    // one-cycle reset pulse at edge 40 restarts the sequence
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(39);
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(70);
    // bypass mid-release, reset toggled under it
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(20);
    tm = 1'b1; tick(3);
    rst = 1'b1; tick(2);
    rst = 1'b0; tick(5);
    tm = 1'b0; tick(70);
`ifdef RESET_SEQ_SOFT_RESET_EN
    // soft_req during release is ignored, then serviced once in RUN
    rst = 1'b1; tick(1);
    rst = 1'b0; tick(19);
    sreq = 1'b1; tick(70);
    sreq = 1'b0; tick(70);
    // soft_req dropped during soft hold
    sreq = 1'b1; tick(1);
    sreq = 1'b0; tick(70);
`endif
    for (int r = 0; r < 1500; r++) begin
      rst = ($urandom_range(0, 99) < 1);
      if ($urandom_range(0, 99) < 3) tm = ~tm;
      if (SOFT && $urandom_range(0, 99) < 4) sreq = ~sreq;
      tick(1);
    end
    tm = 1'b0; sreq = 1'b0; rst = 1'b0;
    tick(80);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
